// File: rtl/computer_param_pkg.sv
// Shared types and helpers for the parameterised accumulator-style CPU:
// opcode and FSM encodings, flag bit positions and instruction geometry.
package computer_param_pkg;

    localparam int OPC_W  = 6;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [5:0] {
        OP_MOV  = 6'd0,  OP_MOVI = 6'd1,  OP_ADD  = 6'd2,  OP_ADDI = 6'd3,
        OP_SUB  = 6'd4,  OP_SUBI = 6'd5,  OP_AND  = 6'd6,  OP_OR   = 6'd7,
        OP_XOR  = 6'd8,  OP_SHL  = 6'd9,  OP_SHR  = 6'd10, OP_CMP  = 6'd11,
        OP_JMP  = 6'd16, OP_JEQ  = 6'd17, OP_JNE  = 6'd18, OP_JLT  = 6'd19,
        OP_JGE  = 6'd20, OP_JGT  = 6'd21, OP_JLE  = 6'd22, OP_JCS  = 6'd23,
        OP_LDI  = 6'd32, OP_STI  = 6'd33, OP_LDR  = 6'd34, OP_STR  = 6'd35,
        OP_CALL = 6'd40, OP_RET  = 6'd41, OP_HALT = 6'd63
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3,
        ALU_OR   = 3'd4, ALU_XOR = 3'd5, ALU_SHL = 3'd6, ALU_SHR = 3'd7
    } alu_op_e;

    function automatic int imm_w(input int data_w, input int addr_w);
        return (data_w > addr_w) ? data_w : addr_w;
    endfunction

    // Layout, MSB first: opcode | rd | rs | imm
    function automatic int instr_w(input int data_w, input int addr_w, input int num_regs);
        return OPC_W + 2 * $clog2(num_regs) + imm_w(data_w, addr_w);
    endfunction

    function automatic logic branch_taken(input opcode_e op, input logic [3:0] flags);
        logic lt;
        logic taken;
        lt = flags[FLAG_N] ^ flags[FLAG_V];
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JEQ:  taken = flags[FLAG_Z];
            OP_JNE:  taken = !flags[FLAG_Z];
            OP_JLT:  taken = lt;
            OP_JGE:  taken = !lt;
            OP_JGT:  taken = !flags[FLAG_Z] && !lt;
            OP_JLE:  taken = flags[FLAG_Z] || lt;
            OP_JCS:  taken = flags[FLAG_C];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/computer_param_alu.sv
// Combinational ALU: result plus {carry/borrow/shift-out, signed overflow}.
module alu_param
    import computer_param_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        cv
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Operation select; the extra top bit of diff_s is the unsigned borrow.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
        result = b;
        cv     = 2'b00;
        case (op)
            ALU_ADD: begin
                result = sum_s[DATA_W-1:0];
                cv     = {sum_s[DATA_W],
                          (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1])};
            end
            ALU_SUB: begin
                result = diff_s[DATA_W-1:0];
                cv     = {diff_s[DATA_W],
                          (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1])};
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                cv     = {a[DATA_W-1], 1'b0};
            end
            ALU_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                cv     = {a[0], 1'b0};
            end
            ALU_PASS: result = b;
            default:  result = b;
        endcase
    end

endmodule

// File: rtl/computer_param.sv
// Multi-cycle CPU: FETCH -> EXEC (-> MEM) -> FETCH, with a return-address
// stack and a terminal HALT state left only through reset.
module computer_param
    import computer_param_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int ADDR_W      = 8,
    parameter  int NUM_REGS    = 4,
    parameter  int STACK_DEPTH = 4,
    localparam int INSTR_W     = instr_w(DATA_W, ADDR_W, NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [3:0]         flags_out,
    output logic               halted,
    output logic               fault
);

    localparam int IMM_W = imm_w(DATA_W, ADDR_W);
    localparam int RW    = $clog2(NUM_REGS);
    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int SIW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    state_e             state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] ir_r;
    logic [3:0]         flags_r;
    logic [DATA_W-1:0]  regs_r [NUM_REGS];
    logic [ADDR_W-1:0]  stack_r [STACK_DEPTH];
    logic [SPW-1:0]     sp_r;
    logic               halted_r;
    logic               fault_r;
    logic               dmem_req_r;
    logic               dmem_we_r;
    logic [ADDR_W-1:0]  dmem_addr_r;
    logic [DATA_W-1:0]  dmem_wdata_r;

    opcode_e            op_s;
    logic [RW-1:0]      rd_s;
    logic [RW-1:0]      rs_s;
    logic [IMM_W-1:0]   imm_s;
    logic [DATA_W-1:0]  rd_val_s;
    logic [DATA_W-1:0]  rs_val_s;
    logic [DATA_W-1:0]  alu_b_s;
    logic [DATA_W-1:0]  alu_res_s;
    logic [1:0]         alu_cv_s;
    alu_op_e            alu_op_s;
    logic               alu_zero_s;
    logic [ADDR_W-1:0]  pc_inc_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [SPW-1:0]     sp_dec_s;
    logic               stack_full_s;
    logic               stack_empty_s;

    // Instruction decode and operand selection from the latched IR.
    always_comb begin
        op_s          = opcode_e'(ir_r[INSTR_W-1 -: OPC_W]);
        rd_s          = ir_r[IMM_W + RW +: RW];
        rs_s          = ir_r[IMM_W +: RW];
        imm_s         = ir_r[IMM_W-1:0];
        rd_val_s      = regs_r[rd_s];
        rs_val_s      = regs_r[rs_s];
        pc_inc_s      = pc_r + ADDR_W'(1);
        sp_dec_s      = sp_r - SPW'(1);
        stack_full_s  = (sp_r == SPW'(STACK_DEPTH));
        stack_empty_s = (sp_r == SPW'(0));
        alu_zero_s    = (alu_res_s == DATA_W'(0));
        if (op_s == OP_MOVI || op_s == OP_ADDI || op_s == OP_SUBI) begin
            alu_b_s = imm_s[DATA_W-1:0];
        end else begin
            alu_b_s = rs_val_s;
        end
        if (op_s == OP_LDI || op_s == OP_STI) begin
            mem_addr_s = imm_s[ADDR_W-1:0];
        end else begin
            mem_addr_s = ADDR_W'(rs_val_s);
        end
        case (op_s)
            OP_ADD, OP_ADDI:         alu_op_s = ALU_ADD;
            OP_SUB, OP_SUBI, OP_CMP: alu_op_s = ALU_SUB;
            OP_AND:                  alu_op_s = ALU_AND;
            OP_OR:                   alu_op_s = ALU_OR;
            OP_XOR:                  alu_op_s = ALU_XOR;
            OP_SHL:                  alu_op_s = ALU_SHL;
            OP_SHR:                  alu_op_s = ALU_SHR;
            default:                 alu_op_s = ALU_PASS;
        endcase
    end

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .a      (rd_val_s),
        .b      (alu_b_s),
        .op     (alu_op_s),
        .result (alu_res_s),
        .cv     (alu_cv_s)
    );

    // Sequencer: all architectural state changes, reset dominating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= '0;
            ir_r         <= '0;
            flags_r      <= 4'b0000;
            sp_r         <= '0;
            halted_r     <= 1'b0;
            fault_r      <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= '0;
            dmem_wdata_r <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir_r    <= imem_data;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_r <= ST_FETCH;
                    case (op_s)
                        OP_MOV, OP_MOVI: begin
                            regs_r[rd_s]    <= alu_res_s;
                            flags_r[FLAG_Z] <= alu_zero_s;
                            flags_r[FLAG_N] <= alu_res_s[DATA_W-1];
                            pc_r            <= pc_inc_s;
                        end
                        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR,
                        OP_XOR, OP_SHL, OP_SHR: begin
                            regs_r[rd_s] <= alu_res_s;
                            flags_r      <= {alu_zero_s, alu_res_s[DATA_W-1], alu_cv_s};
                            pc_r         <= pc_inc_s;
                        end
                        OP_CMP: begin
                            flags_r <= {alu_zero_s, alu_res_s[DATA_W-1], alu_cv_s};
                            pc_r    <= pc_inc_s;
                        end
                        OP_JMP, OP_JEQ, OP_JNE, OP_JLT, OP_JGE, OP_JGT, OP_JLE, OP_JCS: begin
                            pc_r <= branch_taken(op_s, flags_r) ? imm_s[ADDR_W-1:0] : pc_inc_s;
                        end
                        OP_LDI, OP_LDR, OP_STI, OP_STR: begin
                            dmem_req_r   <= 1'b1;
                            dmem_we_r    <= (op_s == OP_STI) || (op_s == OP_STR);
                            dmem_addr_r  <= mem_addr_s;
                            dmem_wdata_r <= rd_val_s;
                            state_r      <= ST_MEM;
                        end
                        OP_CALL: begin
                            if (stack_full_s) begin
                                fault_r  <= 1'b1;
                                halted_r <= 1'b1;
                                state_r  <= ST_HALT;
                            end else begin
                                stack_r[sp_r[SIW-1:0]] <= pc_inc_s;
                                sp_r                   <= sp_r + SPW'(1);
                                pc_r                   <= imm_s[ADDR_W-1:0];
                            end
                        end
                        OP_RET: begin
                            if (stack_empty_s) begin
                                fault_r  <= 1'b1;
                                halted_r <= 1'b1;
                                state_r  <= ST_HALT;
                            end else begin
                                pc_r <= stack_r[sp_dec_s[SIW-1:0]];
                                sp_r <= sp_dec_s;
                            end
                        end
                        OP_HALT: begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end
                        default: begin
                            fault_r  <= 1'b1;
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        if (!dmem_we_r) regs_r[rd_s] <= dmem_rdata;
                        pc_r    <= pc_inc_s;
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: halted_r <= 1'b1;
                default: begin
                    fault_r  <= 1'b1;
                    halted_r <= 1'b1;
                    state_r  <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_addr  = pc_r;
    assign pc_out     = pc_r;
    assign flags_out  = flags_r;
    assign halted     = halted_r;
    assign fault      = fault_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;

endmodule

// File: tb/tb_computer_param.sv
// Bench for computer_param: instruction-level reference model, per-cycle
// output comparison, directed scenarios and randomized programs.
module tb_computer_param;
    import computer_param_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [17:0] imem_data;
    logic        imem_valid;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  pc_out;
    logic [3:0]  flags_out;
    logic        halted, fault;

    computer_param #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_valid(imem_valid), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .pc_out(pc_out), .flags_out(flags_out),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic [7:0] m_r [4];
    logic [3:0] m_f;
    logic [7:0] m_stk [$];
    logic       m_halt, m_fault;
    logic [7:0] mem [256];

    // Expected outputs for the current cycle
    logic [7:0] e_pc, e_addr, e_wdata;
    logic [3:0] e_flags;
    logic       e_halt, e_fault, e_req, e_we;
    bit         chk_en = 1'b0;
    logic [7:0] last_addr, last_wdata;

    localparam logic [5:0] OPS [26] = '{
        OP_MOV, OP_MOVI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR, OP_XOR,
        OP_SHL, OP_SHR, OP_CMP, OP_JMP, OP_JEQ, OP_JNE, OP_JLT, OP_JGE, OP_JGT,
        OP_JLE, OP_JCS, OP_LDI, OP_STI, OP_LDR, OP_STR, OP_CALL, OP_RET};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_out", pc_out, e_pc);
            chk("imem_addr", imem_addr, e_pc);
            chk("flags_out", flags_out, e_flags);
            chk("halted", halted, e_halt);
            chk("fault", fault, e_fault);
            chk("dmem_req", dmem_req, e_req);
            if (e_req) begin
                chk("dmem_we", dmem_we, e_we);
                chk("dmem_addr", dmem_addr, e_addr);
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] mk(input logic [5:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic bit is_mem(input logic [5:0] op);
        return op == OP_LDI || op == OP_STI || op == OP_LDR || op == OP_STR;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync();
        e_pc = m_pc; e_flags = m_f; e_halt = m_halt; e_fault = m_fault;
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_f = 4'h0; m_halt = 1'b0; m_fault = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_stk.delete();
        e_req = 1'b0; e_we = 1'b0;
        sync();
    endtask

    task automatic do_reset();
        rst = 1'b0; imem_valid = 1'($urandom); dmem_ack = 1'($urandom);
        tick();
        rst = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic set_zn(input logic [7:0] res);
        m_f[3] = (res == 8'h00);
        m_f[2] = res[7];
    endtask

    // One non-memory instruction, computed from the instruction-set rules.
    task automatic model_exec(input logic [5:0] op, input logic [1:0] rd,
                              input logic [1:0] rs, input logic [7:0] imm);
        logic [7:0] a, b, res;
        logic [8:0] wide;
        logic z, n, c, v;
        bit take;
        a = m_r[rd];
        b = (op == OP_ADDI || op == OP_SUBI) ? imm : m_r[rs];
        z = m_f[3]; n = m_f[2]; c = m_f[1]; v = m_f[0];
        take = 1'b0;
        case (op)
            OP_MOV:  begin m_r[rd] = m_r[rs]; set_zn(m_r[rs]); m_pc++; end
            OP_MOVI: begin m_r[rd] = imm; set_zn(imm); m_pc++; end
            OP_ADD, OP_ADDI: begin
                wide = {1'b0, a} + {1'b0, b}; res = wide[7:0];
                m_r[rd] = res; set_zn(res);
                m_f[1] = wide[8]; m_f[0] = (a[7] == b[7]) && (res[7] != a[7]); m_pc++;
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                res = a - b;
                if (op != OP_CMP) m_r[rd] = res;
                set_zn(res);
                m_f[1] = (a < b); m_f[0] = (a[7] != b[7]) && (res[7] != a[7]); m_pc++;
            end
            OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                c = 1'b0;
                if (op == OP_AND) res = a & b;
                else if (op == OP_OR) res = a | b;
                else if (op == OP_XOR) res = a ^ b;
                else if (op == OP_SHL) begin res = a << 1; c = a[7]; end
                else begin res = a >> 1; c = a[0]; end
                m_r[rd] = res; set_zn(res); m_f[1] = c; m_f[0] = 1'b0; m_pc++;
            end
            OP_JMP, OP_JEQ, OP_JNE, OP_JLT, OP_JGE, OP_JGT, OP_JLE, OP_JCS: begin
                case (op)
                    OP_JMP:  take = 1'b1;
                    OP_JEQ:  take = z;
                    OP_JNE:  take = !z;
                    OP_JLT:  take = (n != v);
                    OP_JGE:  take = (n == v);
                    OP_JGT:  take = !z && (n == v);
                    OP_JLE:  take = z || (n != v);
                    default: take = c;
                endcase
                m_pc = take ? imm : m_pc + 8'd1;
            end
            OP_CALL: begin
                if (m_stk.size() == 4) begin m_fault = 1'b1; m_halt = 1'b1; end
                else begin m_stk.push_back(m_pc + 8'd1); m_pc = imm; end
            end
            OP_RET: begin
                if (m_stk.size() == 0) begin m_fault = 1'b1; m_halt = 1'b1; end
                else m_pc = m_stk.pop_back();
            end
            OP_HALT: m_halt = 1'b1;
            default: begin m_fault = 1'b1; m_halt = 1'b1; end
        endcase
    endtask

    // Present one instruction, then follow it through execution (and memory).
    task automatic run(input logic [17:0] ins, input int idle, input int wt, input bit abort);
        logic [5:0] op;
        logic [1:0] rd, rs;
        logic [7:0] imm, addr;
        op = ins[17:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
        repeat (idle) begin
            imem_valid = 1'b0; imem_data = 18'($urandom); dmem_ack = 1'($urandom);
            tick();
        end
        imem_valid = 1'b1; imem_data = ins; dmem_ack = 1'($urandom);
        tick();
        imem_valid = 1'b0; imem_data = 18'($urandom); dmem_ack = 1'($urandom);
        if (is_mem(op)) begin
            addr = (op == OP_LDI || op == OP_STI) ? imm : m_r[rs];
            tick();
            e_req = 1'b1; e_we = (op == OP_STI || op == OP_STR);
            e_addr = addr; e_wdata = m_r[rd];
            dmem_ack = 1'b0;
            repeat (wt) begin imem_valid = 1'($urandom); tick(); end
            imem_valid = 1'b0;
            if (abort) begin
                rst = 1'b0; dmem_ack = 1'b1;
                tick();
                rst = 1'b1; dmem_ack = 1'b0;
                model_reset();
                return;
            end
            dmem_ack = 1'b1;
            dmem_rdata = e_we ? 8'($urandom) : mem[addr];
            last_addr = dmem_addr; last_wdata = dmem_wdata;
            tick();
            dmem_ack = 1'b0;
            if (e_we) mem[addr] = e_wdata;
            else m_r[rd] = dmem_rdata;
            m_pc = m_pc + 8'd1;
            e_req = 1'b0;
            sync();
        end else begin
            model_exec(op, rd, rs, imm);
            tick();
            sync();
        end
    endtask

    task automatic halt_idle(input int n);
        repeat (n) begin
            imem_valid = 1'b1; imem_data = 18'($urandom); dmem_ack = 1'($urandom);
            tick();
        end
        imem_valid = 1'b0;
    endtask

    function automatic logic [17:0] rand_instr();
        int r;
        logic [5:0] op;
        r = $urandom_range(0, 99);
        if (r == 0) op = 6'h3D;
        else if (r == 1) op = OP_HALT;
        else op = OPS[$urandom_range(0, 25)];
        return {op, 2'($urandom), 2'($urandom), 8'($urandom)};
    endfunction

    initial begin
        imem_valid = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = 8'h00;
        e_req = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        tick();
        do_reset();
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_flags", flags_out, 4'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_req", dmem_req, 1'b0);

        // Back-to-back ALU instructions, two cycles each
        run(mk(OP_MOVI, 2'd0, 2'd0, 8'd5), 0, 0, 0);
        run(mk(OP_MOVI, 2'd1, 2'd0, 8'd3), 0, 0, 0);
        run(mk(OP_ADD, 2'd0, 2'd1, 8'd0), 0, 0, 0);
        chk("add_pc", pc_out, 8'h03);
        chk("add_flags", flags_out, 4'b0000);
        run(mk(OP_STI, 2'd0, 2'd0, 8'h00), 0, 0, 0);
        chk("add_r0", last_wdata, 8'h08);

        // Signed overflow then zero
        run(mk(OP_MOVI, 2'd0, 2'd0, 8'h7F), 0, 0, 0);
        run(mk(OP_ADDI, 2'd0, 2'd0, 8'h01), 0, 0, 0);
        chk("ovf_flags", flags_out, 4'b0101);
        run(mk(OP_STI, 2'd0, 2'd0, 8'h01), 1, 0, 0);
        chk("ovf_r0", last_wdata, 8'h80);
        run(mk(OP_SUBI, 2'd0, 2'd0, 8'h80), 0, 0, 0);
        chk("zero_flags", flags_out, 4'b1000);

        // Compare and conditional branch, taken and not taken
        run(mk(OP_MOVI, 2'd0, 2'd0, 8'd2), 0, 0, 0);
        run(mk(OP_MOVI, 2'd1, 2'd0, 8'd3), 0, 0, 0);
        run(mk(OP_CMP, 2'd0, 2'd1, 8'd0), 0, 0, 0);
        run(mk(OP_JLT, 2'd0, 2'd0, 8'h10), 0, 0, 0);
        chk("jlt_taken_pc", pc_out, 8'h10);
        run(mk(OP_MOVI, 2'd1, 2'd0, 8'd1), 0, 0, 0);
        run(mk(OP_CMP, 2'd0, 2'd1, 8'd0), 0, 0, 0);
        run(mk(OP_JLT, 2'd0, 2'd0, 8'h40), 0, 0, 0);
        chk("jlt_fall_pc", pc_out, 8'h13);

        // Store with delayed acknowledge, then load back
        run(mk(OP_MOVI, 2'd1, 2'd0, 8'hA5), 0, 0, 0);
        run(mk(OP_STI, 2'd1, 2'd0, 8'h20), 0, 2, 0);
        chk("st_addr", last_addr, 8'h20);
        chk("st_data", last_wdata, 8'hA5);
        mem[8'h20] = 8'h5A;
        run(mk(OP_LDI, 2'd2, 2'd0, 8'h20), 0, 1, 0);
        run(mk(OP_STI, 2'd2, 2'd0, 8'h21), 0, 0, 0);
        chk("ld_r2", last_wdata, 8'h5A);

        // PC wraps from the top of the address space
        run(mk(OP_JMP, 2'd0, 2'd0, 8'hFF), 0, 0, 0);
        run(mk(OP_MOVI, 2'd3, 2'd0, 8'h00), 0, 0, 0);
        chk("pc_wrap", pc_out, 8'h00);

        // Stack overflow and underflow
        do_reset();
        run(mk(OP_CALL, 2'd0, 2'd0, 8'h40), 0, 0, 0);
        run(mk(OP_CALL, 2'd0, 2'd0, 8'h50), 0, 0, 0);
        run(mk(OP_CALL, 2'd0, 2'd0, 8'h60), 0, 0, 0);
        run(mk(OP_CALL, 2'd0, 2'd0, 8'h70), 0, 0, 0);
        run(mk(OP_CALL, 2'd0, 2'd0, 8'h80), 0, 0, 0);
        chk("ovf_call_pc", pc_out, 8'h70);
        chk("ovf_call_fault", fault, 1'b1);
        chk("ovf_call_halted", halted, 1'b1);
        halt_idle(4);
        chk("halt_pc_hold", pc_out, 8'h70);
        do_reset();
        run(mk(OP_RET, 2'd0, 2'd0, 8'h00), 0, 0, 0);
        chk("udf_ret_pc", pc_out, 8'h00);
        chk("udf_ret_fault", fault, 1'b1);
        do_reset();
        run(mk(OP_CALL, 2'd0, 2'd0, 8'h44), 0, 0, 0);
        run(mk(OP_RET, 2'd0, 2'd0, 8'h00), 0, 0, 0);
        chk("ret_pc", pc_out, 8'h01);
        run(mk(OP_HALT, 2'd0, 2'd0, 8'h00), 0, 0, 0);
        chk("halt_op_halted", halted, 1'b1);
        chk("halt_op_fault", fault, 1'b0);
        halt_idle(3);
        do_reset();
        run(mk(6'h3D, 2'd0, 2'd0, 8'h00), 0, 0, 0);
        chk("undef_fault", fault, 1'b1);

        // Reset in the middle of a memory wait
        do_reset();
        run(mk(OP_MOVI, 2'd3, 2'd0, 8'h33), 0, 0, 0);
        run(mk(OP_STI, 2'd3, 2'd0, 8'h30), 0, 2, 1);
        chk("abort_req", dmem_req, 1'b0);
        chk("abort_pc", pc_out, 8'h00);
        for (int r = 0; r < 4; r++) begin
            run(mk(OP_STI, 2'(r), 2'd0, 8'(8'h30 + r)), 0, 0, 0);
            chk("abort_reg_zero", last_wdata, 8'h00);
        end

        // Randomized programs
        for (int seg = 0; seg < 40; seg++) begin
            do_reset();
            for (int k = 0; k < 40 && !m_halt; k++)
                run(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                    ($urandom_range(0, 59) == 0));
            if (m_halt) halt_idle(3);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
